// File: rtl/hc_piso_tx.sv
// hc_piso_tx: parallel-in/serial-out transmitter, MSB first, complementary outputs.
// All state updates on the falling edge of Clk; R is an asynchronous active-low reset.
//
// Ports:
//   Clk   - clock, falling-edge active
//   R     - asynchronous active-low reset
//   Ld    - load request; accepted in idle, or on the final bit edge for a back-to-back word
//   D     - parallel word captured on an accepted load
//   En    - shift enable; low stalls an in-flight word (does not gate a load from idle)
//   Ds    - serial fill bit shifted into the LSB on each shift
//   Q     - serial data out (IDLE_LVL while idle or in reset)
//   Qn    - always ~Q
//   Busy  - high while a word is being transmitted
//   Done  - one-period pulse after the last bit period of a word
module hc_piso_tx #(
   parameter int unsigned WIDTH    = 8,
   parameter logic        IDLE_LVL = 1'b0
) (
   input  logic             Clk,
   input  logic             R,
   input  logic             Ld,
   input  logic [WIDTH-1:0] D,
   input  logic             En,
   input  logic             Ds,
   output logic             Q,
   output logic             Qn,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_sr, w_sr_d;
   logic [CntW-1:0]  r_cnt, w_cnt_d;
   logic             r_done, w_done_d;

   always_ff @(negedge Clk or negedge R) begin
      if (!R) begin
         r_state <= StIdle;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_sr    <= w_sr_d;
         r_cnt   <= w_cnt_d;
         r_done  <= w_done_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_sr_d    = r_sr;
      w_cnt_d   = r_cnt;
      w_done_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (Ld) begin
               w_sr_d    = D;
               w_cnt_d   = CntMax;
               w_state_d = StShift;
            end
         end
         StShift: begin
            if (En) begin
               if (r_cnt != '0) begin
                  w_sr_d  = {r_sr[WIDTH-2:0], Ds};
                  w_cnt_d = r_cnt - 1'b1;
               end else begin
                  w_done_d = 1'b1;
                  if (Ld) begin
                     // Back-to-back reload: new MSB appears with no idle gap.
                     w_sr_d  = D;
                     w_cnt_d = CntMax;
                  end else begin
                     // Drop any Ds refill so nothing stale survives into idle.
                     w_sr_d    = '0;
                     w_state_d = StIdle;
                  end
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs come from registers only; no input reaches Q combinationally.
   assign Busy = (r_state == StShift);
   assign Done = r_done;
   assign Q    = Busy ? r_sr[WIDTH-1] : IDLE_LVL;
   assign Qn   = ~Q;

endmodule

// File: tb/tb_hc_piso_tx.sv
// Bench for hc_piso_tx: directed steps, expected per-period outputs queued as each
// stimulus is driven and popped after the following falling edge.
module tb_hc_piso_tx;

   localparam int unsigned W = 8;

   logic         Clk = 1'b1;
   logic         R;
   logic         Ld;
   logic [W-1:0] D;
   logic         En;
   logic         Ds;
   logic         Q, Qn, Busy, Done;

   typedef struct packed {
      logic q;
      logic busy;
      logic done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   hc_piso_tx #(.WIDTH(W), .IDLE_LVL(1'b0)) dut (
      .Clk  (Clk),
      .R    (R),
      .Ld   (Ld),
      .D    (D),
      .En   (En),
      .Ds   (Ds),
      .Q    (Q),
      .Qn   (Qn),
      .Busy (Busy),
      .Done (Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push_bit(input logic q, input logic busy, input logic done);
      exp_t e;
      e.q    = q;
      e.busy = busy;
      e.done = done;
      sb.push_back(e);
   endtask

   // Expected busy periods of a full word; first_done marks a back-to-back reload period.
   task automatic push_word(input logic [W-1:0] w, input logic first_done);
      for (int i = 0; i < W; i++) push_bit(w[W-1-i], 1'b1, (i == 0) ? first_done : 1'b0);
   endtask

   task automatic push_end();
      push_bit(1'b0, 1'b0, 1'b1);
      push_bit(1'b0, 1'b0, 1'b0);
   endtask

   // Drive inputs, let one falling edge pass, then compare on the rising edge.
   task automatic cycle(input logic ld, input logic [W-1:0] d, input logic en, input logic ds,
                        input string tag);
      exp_t e;
      Ld = ld;
      D  = d;
      En = en;
      Ds = ds;
      @(negedge Clk);
      @(posedge Clk);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_q"}, Q, e.q);
         chk({tag, "_qn"}, Qn, ~e.q);
         chk({tag, "_busy"}, Busy, e.busy);
         chk({tag, "_done"}, Done, e.done);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_q"}, Q, 1'b0);
      chk({tag, "_qn"}, Qn, 1'b1);
      chk({tag, "_busy"}, Busy, 1'b0);
      chk({tag, "_done"}, Done, 1'b0);
   endtask

   initial begin
      // Reset with a load request pending: must be ignored.
      R  = 1'b0;
      Ld = 1'b1;
      D  = 8'hFF;
      En = 1'b1;
      Ds = 1'b0;
      repeat (3) @(posedge Clk);
      chk_idle("reset");
      R  = 1'b1;
      Ld = 1'b0;

      // Single word A5.
      push_word(8'hA5, 1'b0);
      push_end();
      cycle(1'b1, 8'hA5, 1'b1, 1'b0, "single");
      repeat (W + 1) cycle(1'b0, 8'h00, 1'b1, 1'b0, "single");

      // Stall: F0 with En low for 3 periods after bit 2 is shown.
      push_bit(1'b1, 1'b1, 1'b0);
      push_bit(1'b1, 1'b1, 1'b0);
      repeat (4) push_bit(1'b1, 1'b1, 1'b0);
      push_bit(1'b1, 1'b1, 1'b0);
      repeat (4) push_bit(1'b0, 1'b1, 1'b0);
      push_end();
      cycle(1'b1, 8'hF0, 1'b1, 1'b0, "stall");
      repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0, "stall");
      repeat (3) cycle(1'b1, 8'h0F, 1'b0, 1'b0, "stall");
      repeat (7) cycle(1'b0, 8'h00, 1'b1, 1'b0, "stall");

      // Back-to-back 81 then 3C.
      push_word(8'h81, 1'b0);
      push_word(8'h3C, 1'b1);
      push_end();
      cycle(1'b1, 8'h81, 1'b1, 1'b0, "b2b");
      repeat (W - 1) cycle(1'b0, 8'h00, 1'b1, 1'b0, "b2b");
      cycle(1'b1, 8'h3C, 1'b1, 1'b0, "b2b");
      repeat (W + 1) cycle(1'b0, 8'h00, 1'b1, 1'b0, "b2b");

      // Ignored load mid-word; Ds=1 fill must never show on Q.
      push_word(8'h00, 1'b0);
      push_end();
      cycle(1'b1, 8'h00, 1'b1, 1'b1, "ignld");
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b1, "ignld");
      cycle(1'b1, 8'hFF, 1'b1, 1'b1, "ignld");
      repeat (W - 5 + 2) cycle(1'b0, 8'h00, 1'b1, 1'b1, "ignld");

      // Abort during bit 5 of A5.
      push_bit(1'b1, 1'b1, 1'b0);
      push_bit(1'b0, 1'b1, 1'b0);
      push_bit(1'b1, 1'b1, 1'b0);
      push_bit(1'b0, 1'b1, 1'b0);
      push_bit(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'hA5, 1'b1, 1'b1, "abort");
      repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b1, "abort");
      #2 R = 1'b0;
      #1 chk_idle("abort_now");
      Ld = 1'b1;
      D  = 8'hFF;
      repeat (2) @(negedge Clk);
      @(posedge Clk);
      chk_idle("abort_held");
      R  = 1'b1;
      push_bit(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_rel");
      push_word(8'h5A, 1'b0);
      push_end();
      cycle(1'b1, 8'h5A, 1'b1, 1'b1, "reload");
      repeat (W + 1) cycle(1'b0, 8'h00, 1'b1, 1'b1, "reload");

      chk("sb_drained", (sb.size() == 0), 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
